// File: rtl/wr_uart_rx_monitor.sv
// UART receiver for bench node consoles: oversampled decode, framing check, show-ahead FIFO.
// Optional per-node line logging is enabled with `define WR_UART_MON_LINE_LOG_EN.
module wr_uart_rx_monitor #(
  parameter int unsigned g_clk_freq   = 125000000,
  parameter int unsigned g_baud       = 115200,
  parameter int unsigned g_data_bits  = 8,
  parameter int unsigned g_fifo_depth = 16,
  parameter int unsigned g_node_id    = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  rxd_i,
  output logic [g_data_bits-1:0]                data_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [$clog2(g_fifo_depth+1)-1:0]     level_o,
  output logic                                  frame_err_o,
  output logic                                  overflow_o
);

  localparam int unsigned DIV     = g_clk_freq / g_baud;
  localparam int unsigned HALF_M1 = DIV / 2 - 1;
  localparam int unsigned CNT_W   = $clog2(DIV);
  localparam int unsigned BIT_W   = $clog2(g_data_bits + 1);
  localparam int unsigned PTR_W   = $clog2(g_fifo_depth);
  localparam int unsigned LVL_W   = $clog2(g_fifo_depth + 1);

  if (DIV < 4) begin : g_div_chk
    $error("wr_uart_rx_monitor: clock/baud divider %0d is below 4", DIV);
  end
  if (g_data_bits < 5 || g_data_bits > 9) begin : g_bits_chk
    $error("wr_uart_rx_monitor: g_data_bits %0d outside 5..9", g_data_bits);
  end
  if (g_fifo_depth < 2 || (g_fifo_depth & (g_fifo_depth - 1)) != 0) begin : g_depth_chk
    $error("wr_uart_rx_monitor: g_fifo_depth %0d must be a power of two >= 2", g_fifo_depth);
  end
  if (g_node_id > 9999) begin : g_node_chk
    $error("wr_uart_rx_monitor: g_node_id %0d out of range", g_node_id);
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                   rx_meta, rxs, rxs_q;
  logic                   fall;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [g_data_bits-1:0] shreg;
  logic                   cnt_end, push_req, push, pop, full;
  logic [g_data_bits-1:0] mem [g_fifo_depth];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level_nxt;

  // Two-flop synchronizer plus edge history, all idling high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_meta <= rxd_i;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
    end
  end

  assign fall     = rxs_q & ~rxs;
  assign cnt_end  = (cnt == CNT_W'(DIV - 1));
  assign push_req = (state == STOP) && cnt_end && rxs;
  assign pop      = valid_o && ready_i;
  assign full     = (level_o == LVL_W'(g_fifo_depth));
  assign push     = push_req && (!full || pop);

  // Frame decoder: start check at half bit, then one sample per bit period
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_W'(HALF_M1)) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_end) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[g_data_bits-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(g_data_bits - 1)) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt_end) begin
            cnt         <= '0;
            state       <= IDLE;
            frame_err_o <= ~rxs;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr] <= shreg;
  end

  assign data_o = mem[rd_ptr];

  always_comb begin
    level_nxt = level_o;
    if (push && !pop)      level_nxt = level_o + 1'b1;
    else if (pop && !push) level_nxt = level_o - 1'b1;
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy kept separately
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_o    <= level_nxt;
      valid_o    <= (level_nxt != '0);
      overflow_o <= push_req && full && !pop;
    end
  end

`ifdef WR_UART_MON_LINE_LOG_EN
  string      line_buf;
  logic [7:0] ch;

  assign ch = 8'(shreg);

  // Every well-framed byte is logged, even if the FIFO later drops it
  always @(posedge clk_i) begin
    if (rst_i) begin
      line_buf <= "";
    end else if (push_req) begin
      if (ch == 8'h0A) begin
        $display("[%0t] Node %0d: %s", $time, g_node_id, line_buf);
        line_buf <= "";
      end else if (ch != 8'h0D) begin
        if (line_buf.len() == 127) begin
          $display("[%0t] Node %0d: %s", $time, g_node_id, $sformatf("%s%c", line_buf, ch));
          line_buf <= "";
        end else begin
          line_buf <= $sformatf("%s%c", line_buf, ch);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wr_uart_rx_monitor.sv
// Randomized bench for wr_uart_rx_monitor against a queue-based cycle reference model.
module tb_wr_uart_rx_monitor;

  localparam int unsigned CLK_F = 1000;
  localparam int unsigned BAUD  = 100;
  localparam int unsigned DIV   = CLK_F / BAUD;
  localparam int unsigned NB    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             rxd_i;
  logic [NB-1:0]    data_o;
  logic             valid_o;
  logic             ready_i;
  logic [LVL_W-1:0] level_o;
  logic             frame_err_o;
  logic             overflow_o;

  wr_uart_rx_monitor #(
    .g_clk_freq  (CLK_F),
    .g_baud      (BAUD),
    .g_data_bits (NB),
    .g_fifo_depth(DEPTH),
    .g_node_id   (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rxd_i      (rxd_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycle index, pending frame outcome, expected FIFO contents
  int         cyc = 0;
  int         push_cyc = -1;
  logic       push_good;
  logic [7:0] push_byte;
  logic [7:0] exp_q[$];
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;
  logic       armed = 1'b0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  logic       m_pop, m_push, m_fe, m_ov;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (armed) begin
      check_eq("valid", 32'(valid_o), 32'(exp_q.size() != 0));
      check_eq("level", 32'(level_o), 32'(exp_q.size()));
      if (exp_q.size() != 0) check_eq("data", 32'(data_o), 32'(exp_q[0]));
      check_eq("frame_err", 32'(frame_err_o), 32'(exp_fe));
      check_eq("overflow", 32'(overflow_o), 32'(exp_ov));
      if (frame_err_o) fe_seen++;
      if (overflow_o) ov_seen++;
    end
    if (rst_i) begin
      exp_q.delete();
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      armed  = 1'b1;
    end else begin
      m_pop  = (exp_q.size() != 0) && ready_i;
      m_push = 1'b0;
      m_fe   = 1'b0;
      m_ov   = 1'b0;
      if (cyc == push_cyc) begin
        if (!push_good)                           m_fe = 1'b1;
        else if (exp_q.size() == DEPTH && !m_pop) m_ov = 1'b1;
        else                                      m_push = 1'b1;
      end
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(push_byte);
      exp_fe = m_fe;
      exp_ov = m_ov;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Whole frame; stop sample lands 2 sync cycles + half bit + (NB+1) bits after the start edge
  task automatic send(input logic [7:0] b, input logic stop_ok);
    tick();
    push_byte = b;
    push_good = stop_ok;
    push_cyc  = cyc + 2 + DIV / 2 + (NB + 1) * DIV;
    rxd_i = 1'b0;
    repeat (DIV) tick();
    for (int k = 0; k < NB; k++) begin
      rxd_i = b[k];
      repeat (DIV) tick();
    end
    rxd_i = stop_ok;
    repeat (DIV) tick();
    rxd_i = 1'b1;
  endtask

  task automatic glitch(input int len);
    tick();
    rxd_i = 1'b0;
    repeat (len) tick();
    rxd_i = 1'b1;
    repeat (DIV) tick();
  endtask

  task automatic reset_mid_frame(input logic [7:0] b);
    tick();
    rxd_i = 1'b0;
    repeat (DIV) tick();
    for (int k = 0; k < 3; k++) begin
      rxd_i = b[k];
      repeat (DIV) tick();
    end
    rxd_i = b[3];
    repeat (5) tick();
    rst_i = 1'b1;
    rxd_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  logic rand_done = 1'b0;

  initial begin
    rst_i   = 1'b1;
    rxd_i   = 1'b1;
    ready_i = 1'b1;
    idle(3);
    rst_i = 1'b0;
    idle(5);

    send(8'hA5, 1'b1);
    idle(5);
    glitch(3);
    idle(5);
    check_eq("glitch_fe_count", 32'(fe_seen), 32'd0);

    send(8'h3C, 1'b0);
    idle(5);
    check_eq("fe_count", 32'(fe_seen), 32'd1);
    send(8'h11, 1'b1);
    idle(5);

    ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    idle(3);
    check_eq("ovf_level", 32'(level_o), 32'd4);
    check_eq("ovf_count", 32'(ov_seen), 32'd1);
    ready_i = 1'b1;
    idle(8);
    check_eq("drain_level", 32'(level_o), 32'd0);

    ready_i = 1'b0;
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    idle(3);
    check_eq("queued_level", 32'(level_o), 32'd2);
    reset_mid_frame(8'hC3);
    idle(2);
    check_eq("rst_level", 32'(level_o), 32'd0);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    ready_i = 1'b1;
    idle(20);
    send(8'h7E, 1'b1);
    idle(5);

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int r;
          r = int'($urandom_range(0, 9));
          if (r == 0) glitch(int'($urandom_range(1, 4)));
          else        send(8'($urandom), r != 1);
          idle(int'($urandom_range(0, 6)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          ready_i = ($urandom_range(0, 3) != 0);
          tick();
        end
        ready_i = 1'b1;
      end
    join

    idle(20);
    check_eq("final_level", 32'(level_o), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wr_uart_rx_monitor.md
# wr_uart_rx_monitor

Parametrised UART receiver for the two-node White Rabbit benches; it replaces toggle-only UART monitors with byte-accurate decoding of each node's `uart_txd_o`. It oversamples a single asynchronous line, checks framing, and buffers received bytes in a show-ahead FIFO with a valid/ready handshake. It can optionally log complete text lines per node.

## Interface
- `g_clk_freq`, 125000000: clock frequency in Hz.
- `g_baud`, 115200: line rate in baud.
  - Divider DIV = g_clk_freq / g_baud, integer truncation.
  - DIV < 4 is an elaboration `$error`.
- `g_data_bits`, 8: data bits per frame, range 5..9, LSB first, no parity, one stop bit.
- `g_fifo_depth`, 16: FIFO entries, power of two, ≥ 2.
- `g_node_id`, 0: node number used in log text.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `rxd_i` in 1: asynchronous serial input, idle high.
- `data_o` out g_data_bits: head-of-FIFO byte, valid when `valid_o`=1.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: consumer accepts `data_o` when `valid_o && ready_i`.
- `level_o` out $clog2(g_fifo_depth+1): FIFO occupancy.
- `frame_err_o` out 1: one-cycle pulse on bad stop bit.
- `overflow_o` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- `rxd_i` passes through a 2-flop synchronizer, reset to 1; `rxs` is the synchronizer output. An edge detector on `rxs` finds falling edges.
- FSM states IDLE, START, DATA, STOP, with a bit counter and a DIV-cycle counter.
- IDLE → START on a falling edge of `rxs`. The cycle counter loads 0.
- START: at count DIV/2−1 (integer), sample `rxs`.
  - 0 → DATA, counter cleared.
  - 1 → IDLE (glitch rejected, no error).
- DATA: every DIV cycles, shift `rxs` in at MSB of a g_data_bits shift register (LSB-first line order). After g_data_bits samples → STOP.
- STOP: after DIV cycles, sample `rxs`.
  - 1 → push byte and go to IDLE.
  - 0 → `frame_err_o` pulse, byte discarded, go to IDLE. A new frame requires a fresh falling edge, so a held-low line is not re-decoded.
- FIFO is show-ahead; `data_o` reflects the head entry combinationally from the storage array.
  - Pop when `valid_o && ready_i`.
  - Push when full and no pop that cycle: byte dropped, `overflow_o` pulse.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
  - Push and pop in the same cycle while empty is impossible, since `valid_o`=0.
- Pointers wrap modulo g_fifo_depth. `level_o` is tracked as a separate counter.
- `rst_i` mid-frame: FSM → IDLE, FIFO emptied, partial byte lost. The first post-reset frame is recognised only after a falling edge.

## Timing
Reset values:
- `valid_o`=0, `level_o`=0, `frame_err_o`=0, `overflow_o`=0.
- `data_o` = contents of entry 0 (don't-care).
- Synchronizer flops = 1, FSM = IDLE.

Sample points, with t0 = the cycle the falling edge is seen on `rxs` (2–3 clk after the `rxd_i` edge):
- Start check: t0 + DIV/2.
- Data bit k (0-based): t0 + DIV/2 + (k+1)·DIV.
- Stop bit: t0 + DIV/2 + (g_data_bits+1)·DIV.

Output latency:
- Push is registered at the stop-sample edge.
- `valid_o` and `level_o` update on the next cycle.
- `frame_err_o` and `overflow_o` assert the cycle after the stop sample, for exactly one cycle.
- A pop updates `level_o` and `valid_o` on the next edge. Back-to-back pops are allowed every cycle.

## Configuration
- `WR_UART_MON_LINE_LOG_EN` defined:
  - Every correctly framed byte is appended to a 128-character line buffer, including bytes later dropped by overflow.
  - 0x0D is ignored.
  - 0x0A prints `[%0t] Node %0d: <line>` via `$display` and clears the buffer.
  - At 128 characters the buffer is printed and cleared without waiting for 0x0A.
  - Reset clears the buffer without printing.
- Undefined: no line buffer and no `$display`. All port behaviour is identical in both cases.

## Test plan
Use g_clk_freq=1000, g_baud=100 (DIV=10), g_fifo_depth=4, ready_i=1 unless noted.
- **Single byte:** send 0xA5 → one byte `data_o`=0xA5, `valid_o` high 1 cycle after the stop sample, `level_o`=1, no error pulses.
- **Glitch:** drive `rxd_i` low for 3 cycles → no push, no `frame_err_o`, FSM back in IDLE.
- **Framing error:** send 0x3C with the stop bit forced 0 → one `frame_err_o` pulse, `level_o` stays 0. The next valid frame 0x11 is received correctly.
- **Overflow:** with `ready_i`=0, send 0x01..0x05 → `level_o`=4, one `overflow_o` pulse on byte 0x05. Raising `ready_i` then yields 0x01..0x04 in order, one per cycle.
- **Reset mid-frame:** assert `rst_i` for 1 cycle during DATA bit 3 with 2 bytes queued → `level_o`=0, `valid_o`=0. The next frame 0x7E is received correctly.
- **Line log (macro defined):** send "OK\r\n" with g_node_id=2 → exactly one `$display` line ending in `Node 2: OK`.
